// File: rtl/nfc_pkg.sv
// rtl/nfc_pkg.sv - shared NAND controller constants, opcodes and FSM state type
package nfc_pkg;

    localparam int PAGE_BYTES = 512;
    localparam int PAGE_AW    = 9;
    localparam int NUM_PAGES  = 512;

    localparam logic [7:0] CMD_READ0     = 8'h00;
    localparam logic [7:0] CMD_PROG      = 8'h80;
    localparam logic [7:0] CMD_PROG_CONF = 8'h10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WAIT_BSY,
        ST_WAIT_RDY,
        ST_RD_LO,
        ST_RD_HI,
        ST_FLUSH,
        ST_DONE
    } rd_state_t;

    // Address cycle idx of a page read: column byte, then row low, then row high.
    function automatic logic [7:0] addr_byte(input logic [1:0] idx, input logic [PAGE_AW-1:0] pg);
        case (idx)
            2'd1:    return pg[7:0];
            2'd2:    return {7'b0, pg[8]};
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/nand_bus_timer.sv
// rtl/nand_bus_timer.sv - phase down-counter; last marks the final cycle of a loaded phase
module nand_bus_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         last
);

    logic [W-1:0] cnt;

    // load arrives in the first cycle of a phase, so that cycle already counts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val - W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign last = load ? (load_val == W'(1)) : (cnt == W'(1));

endmodule

// File: rtl/nand_page_reader.sv
// rtl/nand_page_reader.sv - NAND page-read sequencer streaming one page out as bytes
module nand_page_reader
    import nfc_pkg::*;
#(
    parameter int T_WL   = 1,
    parameter int T_WH   = 1,
    parameter int T_RL   = 1,
    parameter int T_RH   = 1,
    parameter int WB_MAX = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PAGE_AW-1:0] page,
    output logic               busy,
    output logic               done,
    output logic [7:0]         dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [7:0]         f_io_out,
    output logic               f_io_oe,
    input  logic [7:0]         f_io_in,
    output logic               f_cle,
    output logic               f_ale,
    output logic               f_wen,
    output logic               f_ren,
    input  logic               f_rb
);

    localparam int TW = 4;
    localparam logic [PAGE_AW:0] LAST_CNT = (PAGE_AW+1)'(PAGE_BYTES);

    rd_state_t          state;
    logic               phase;
    logic               hi_done;
    logic [1:0]         addr_idx;
    logic [PAGE_AW-1:0] page_r;
    logic [PAGE_AW:0]   byte_cnt;
    logic               tmr_load;
    logic [TW-1:0]      tmr_val;
    logic               tmr_last;
    logic               rb_meta;
    logic               rb_s;
    logic               can_load;

    assign can_load = !dout_valid || dout_ready;

    nand_bus_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .last     (tmr_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            rb_meta <= 1'b1;
            rb_s    <= 1'b1;
        end else begin
            rb_meta <= f_rb;
            rb_s    <= rb_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            phase      <= 1'b0;
            hi_done    <= 1'b0;
            addr_idx   <= 2'd0;
            page_r     <= '0;
            byte_cnt   <= '0;
            tmr_load   <= 1'b0;
            tmr_val    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dout       <= 8'h00;
            dout_valid <= 1'b0;
            f_io_out   <= 8'h00;
            f_io_oe    <= 1'b0;
            f_cle      <= 1'b0;
            f_ale      <= 1'b0;
            f_wen      <= 1'b1;
            f_ren      <= 1'b1;
        end else begin
            tmr_load <= 1'b0;
            done     <= 1'b0;
            if (dout_valid && dout_ready) dout_valid <= 1'b0;

            case (state)
                ST_IDLE: if (start) begin
                    page_r   <= page;
                    busy     <= 1'b1;
                    byte_cnt <= '0;
                    f_cle    <= 1'b1;
                    f_io_oe  <= 1'b1;
                    f_io_out <= CMD_READ0;
                    f_wen    <= 1'b0;
                    phase    <= 1'b0;
                    tmr_load <= 1'b1;
                    tmr_val  <= TW'(T_WL);
                    state    <= ST_CMD;
                end
                ST_CMD, ST_ADDR: if (tmr_last) begin
                    if (!phase) begin
                        f_wen    <= 1'b1;
                        phase    <= 1'b1;
                        tmr_load <= 1'b1;
                        tmr_val  <= TW'(T_WH);
                    end else if (state == ST_CMD || addr_idx != 2'd2) begin
                        f_cle    <= 1'b0;
                        f_ale    <= 1'b1;
                        addr_idx <= (state == ST_CMD) ? 2'd0 : addr_idx + 2'd1;
                        f_io_out <= addr_byte((state == ST_CMD) ? 2'd0 : addr_idx + 2'd1, page_r);
                        f_wen    <= 1'b0;
                        phase    <= 1'b0;
                        tmr_load <= 1'b1;
                        tmr_val  <= TW'(T_WL);
                        state    <= ST_ADDR;
                    end else begin
                        f_ale    <= 1'b0;
                        f_io_oe  <= 1'b0;
                        f_io_out <= 8'h00;
                        tmr_load <= 1'b1;
                        tmr_val  <= TW'(WB_MAX);
                        state    <= ST_WAIT_BSY;
                    end
                end
                // A device that never drops RB is tolerated by timing out after WB_MAX.
                ST_WAIT_BSY: if (!rb_s || tmr_last) state <= ST_WAIT_RDY;
                ST_WAIT_RDY: if (rb_s && can_load) begin
                    f_ren    <= 1'b0;
                    tmr_load <= 1'b1;
                    tmr_val  <= TW'(T_RL);
                    state    <= ST_RD_LO;
                end
                ST_RD_LO: if (tmr_last) begin
                    dout       <= f_io_in;
                    dout_valid <= 1'b1;
                    f_ren      <= 1'b1;
                    byte_cnt   <= byte_cnt + 1'b1;
                    hi_done    <= 1'b0;
                    tmr_load   <= 1'b1;
                    tmr_val    <= TW'(T_RH);
                    state      <= ST_RD_HI;
                end
                // hi_done keeps the high phase satisfied while downstream stalls.
                ST_RD_HI: if (tmr_last || hi_done) begin
                    if (byte_cnt == LAST_CNT) begin
                        state <= ST_FLUSH;
                    end else if (can_load) begin
                        f_ren    <= 1'b0;
                        tmr_load <= 1'b1;
                        tmr_val  <= TW'(T_RL);
                        state    <= ST_RD_LO;
                    end else begin
                        hi_done <= 1'b1;
                    end
                end
                ST_FLUSH: if (can_load) begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nand_page_reader.sv
// tb/tb_nand_page_reader.sv - scoreboard bench with a behavioural NAND read model
module tb_nand_page_reader;
    import nfc_pkg::*;

    localparam int WB = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [PAGE_AW-1:0] page = '0;
    logic               busy, done, dout_valid;
    logic [7:0]         dout, f_io_out, f_io_in;
    logic               dout_ready = 1'b1;
    logic               f_io_oe, f_cle, f_ale, f_wen, f_ren;
    logic               rb = 1'b1;

    int total = 0;
    int bad = 0;

    logic [7:0] exp_q[$];
    logic [9:0] bus_exp_q[$];

    int xfer_cnt = 0, done_cnt = 0, cyc = 0, rcnt = 0;
    bit fast_rb = 0, bp_mode = 0;

    logic [PAGE_AW-1:0] m_page = '0;
    int   m_col = 0, m_addr_n = 0, rb_cnt = 0, ale3_cyc = 0, ren0_cyc = 0;
    bit   pend = 0, first_ren = 0, stall = 0;
    logic [9:0] pend_w = '0;
    logic [7:0] stall_d = '0;
    logic prev_ren = 1'b1;

    always #5 clk = ~clk;

    nand_page_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .page       (page),
        .busy       (busy),
        .done       (done),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .f_io_out   (f_io_out),
        .f_io_oe    (f_io_oe),
        .f_io_in    (f_io_in),
        .f_cle      (f_cle),
        .f_ale      (f_ale),
        .f_wen      (f_wen),
        .f_ren      (f_ren),
        .f_rb       (rb)
    );

    function automatic logic [7:0] img(input int p, input int c);
        return 8'((c + p * 37) ^ (p >> 1));
    endfunction

    assign f_io_in = !f_ren ? img(int'(m_page), m_col) : 8'h00;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Flash model plus stream and bus monitors, all sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            pend = 0; rb = 1'b1; rb_cnt = 0; m_col = 0; m_addr_n = 0;
            prev_ren = 1'b1; stall = 0;
        end else begin
            if (rb_cnt > 0) begin
                rb_cnt--;
                if (rb_cnt == 0) rb = 1'b1;
            end
            if (!f_wen) begin
                pend = 1;
                pend_w = {f_cle, f_ale, f_io_out};
            end else if (pend) begin
                pend = 0;
                check("bus_write_expected", int'(bus_exp_q.size() != 0), 1);
                if (bus_exp_q.size() != 0) check("bus_write", pend_w, bus_exp_q.pop_front());
                if (pend_w[9]) begin
                    m_addr_n = 0;
                end else if (pend_w[8]) begin
                    if (m_addr_n == 1) m_page[7:0] = pend_w[7:0];
                    if (m_addr_n == 2) m_page[8] = pend_w[0];
                    m_addr_n++;
                    if (m_addr_n == 3) begin
                        m_col = 0; ale3_cyc = cyc; first_ren = 1;
                        if (!fast_rb) begin rb = 1'b0; rb_cnt = 3; end
                    end
                end
            end
            if (!f_ren) begin
                check("wen_ren_overlap", f_wen, 1);
                check("ren_while_full", dout_valid, 0);
                if (prev_ren && first_ren) begin ren0_cyc = cyc; first_ren = 0; end
            end
            if (!prev_ren && f_ren) m_col++;
            prev_ren = f_ren;

            if (stall) begin
                check("stall_valid", dout_valid, 1);
                check("stall_data", dout, stall_d);
            end
            if (dout_valid && dout_ready) begin
                xfer_cnt++;
                check("xfer_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("stream_data", dout, exp_q.pop_front());
            end
            stall = dout_valid && !dout_ready;
            stall_d = dout;
            if (done) done_cnt++;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        rcnt++;
        dout_ready = bp_mode ? (rcnt % 4 == 0) : 1'b1;
    end

    task automatic push_page(input logic [PAGE_AW-1:0] p);
        for (int c = 0; c < PAGE_BYTES; c++) exp_q.push_back(img(int'(p), c));
        bus_exp_q.push_back({2'b10, 8'h00});
        bus_exp_q.push_back({2'b01, 8'h00});
        bus_exp_q.push_back({2'b01, p[7:0]});
        bus_exp_q.push_back({2'b01, 7'b0, p[8]});
        xfer_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic pulse_start(input logic [PAGE_AW-1:0] p);
        @(posedge clk); #1;
        start = 1'b1; page = p;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic run_page(input logic [PAGE_AW-1:0] p, input bit chk_gap);
        int n;
        push_page(p);
        pulse_start(p);
        n = 0;
        while (!done && n < 20000) begin @(posedge clk); #1; n++; end
        check("done_timeout", int'(n < 20000), 1);
        @(posedge clk); #1;
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        check("xfer_count", xfer_cnt, PAGE_BYTES);
        check("done_count", done_cnt, 1);
        check("exp_q_empty", exp_q.size(), 0);
        check("bus_q_empty", bus_exp_q.size(), 0);
        if (chk_gap) check("wb_timeout_gap", int'(ren0_cyc - ale3_cyc >= WB && ren0_cyc - ale3_cyc <= WB + 2), 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_f_wen", f_wen, 1);
        check("rst_f_ren", f_ren, 1);
        check("rst_f_cle", f_cle, 0);
        check("rst_f_ale", f_ale, 0);
        check("rst_f_io_oe", f_io_oe, 0);
        check("rst_f_io_out", f_io_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_dout", dout, 0);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b1;

        run_page(9'd0, 0);
        run_page(9'd511, 0);

        bp_mode = 1;
        run_page(9'd100, 0);
        bp_mode = 0;

        fast_rb = 1;
        run_page(9'd42, 1);
        fast_rb = 0;

        fork
            run_page(9'd7, 0);
            begin
                n = 0;
                while (!(m_col == 100 && !f_ren) && n < 5000) begin @(posedge clk); #1; n++; end
                check("reach_byte_100", int'(n < 5000), 1);
                start = 1'b1; page = 9'd9;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join

        push_page(9'd2);
        pulse_start(9'd2);
        n = 0;
        while (xfer_cnt < 200 && n < 5000) begin @(posedge clk); #1; n++; end
        check("reach_byte_200", int'(n < 5000), 1);
        rst = 1'b0;
        exp_q.delete();
        bus_exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        check_reset_outputs();
        run_page(9'd3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nand_page_reader.md
Name: nand_page_reader

Overview:
- Source-side engine of the flash-copy controller: issues the NAND page-read sequence on flash port A and streams the 512 page bytes out on a valid/ready byte interface.
- The downstream page-program stage consumes that stream and writes flash B.
- Drives CLE/ALE/WEN/REN directly; IO tri-state buffering lives in the controller top.

Parameters:
- PAGE_BYTES, 512, bytes streamed per page
- PAGE_AW, 9, page index width (512 pages)
- T_WL, 1, clk cycles F_WEN held low per command/address write
- T_WH, 1, clk cycles F_WEN held high after each write
- T_RL, 1, clk cycles F_REN held low; data sampled on the last low cycle
- T_RH, 1, clk cycles F_REN held high between reads
- WB_MAX, 8, max cycles to wait for F_RB to fall after the last address

Ports:
- clk in 1 system clock, all logic on rising edge
- rst in 1 synchronous, active-low reset
- start in 1 one-cycle request; accepted only in IDLE
- page in PAGE_AW page to read, captured on accepted start
- busy out 1 high from the cycle after start acceptance until done
- done out 1 one-cycle pulse after the last byte is accepted downstream
- dout out 8 streamed byte
- dout_valid out 1 dout holds a valid byte
- dout_ready in 1 downstream accepts a byte when valid&ready
- f_io_out out 8 value driven onto F_IO_A
- f_io_oe out 1 drive enable for F_IO_A
- f_io_in in 8 sampled F_IO_A
- f_cle out 1 F_CLE_A
- f_ale out 1 F_ALE_A
- f_wen out 1 F_WEN_A, active low
- f_ren out 1 F_REN_A, active low
- f_rb in 1 F_RB_A, 1 = ready; asynchronous, two-flop synchronised internally

Behaviour:
- Reset (rst=0 at a clk edge) has priority over everything and is legal mid-operation. It forces:
  - f_cle=0, f_ale=0, f_wen=1, f_ren=1, f_io_oe=0, f_io_out=0
  - busy=0, done=0, dout_valid=0, dout=0
  - FSM to IDLE, byte counter to 0
- FSM states: IDLE, CMD, ADDR, WAIT_BSY, WAIT_RDY, RD_LO, RD_HI, FLUSH, DONE.
- IDLE:
  - start=1 captures page and goes to CMD; busy rises the next cycle.
  - start in any other state is ignored.
- CMD:
  - f_cle=1, f_io_oe=1, f_io_out=8'h00.
  - f_wen low for T_WL cycles, then high for T_WH cycles; CLE and data stay stable for the whole window.
  - Then go to ADDR.
- ADDR:
  - Three write cycles with f_ale=1, same WEN timing as CMD.
  - Bytes in order: 8'h00, page[7:0], {7'b0, page[8]}.
  - After the third: f_ale=0, f_io_oe=0, go to WAIT_BSY.
- WAIT_BSY:
  - Synchronised RB=0 goes to WAIT_RDY.
  - If RB stays 1 for WB_MAX cycles, go to WAIT_RDY anyway.
- WAIT_RDY: synchronised RB=1 goes to RD_LO.
- RD_LO / RD_HI:
  - Entry to RD_LO is permitted only when the output register is empty, or is being emptied this cycle (valid&ready). Otherwise stay with f_ren=1.
  - f_ren=0 for T_RL cycles; f_io_in is latched into dout on the last low cycle; dout_valid is set the next cycle.
  - Then f_ren=1 for T_RH cycles and the byte counter increments.
  - When count reaches PAGE_BYTES, go to FLUSH; otherwise return to RD_LO.
- FLUSH: wait until the final byte is accepted, then go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Output handshake:
  - dout and dout_valid are held stable while valid & !ready.
  - Exactly PAGE_BYTES transfers occur per page, in column order 0..511.
- f_wen and f_ren are never low in the same cycle.
- The byte counter is PAGE_AW+1 bits and never wraps within a page.
- f_io_oe=0 in every state except CMD/ADDR.

Decomposition:
- Shared package nfc_pkg holds:
  - NAND opcodes: CMD_READ0=8'h00, CMD_PROG=8'h80, CMD_PROG_CONF=8'h10
  - PAGE_BYTES, PAGE_AW, NUM_PAGES=512
  - FSM state enum
- One natural sub-module: nand_bus_timer. It is a down-counter issuing phase-done pulses for T_WL/T_WH/T_RL/T_RH/WB_MAX and is reused by the program stage.

Test Plan:
- Page 0, dout_ready=1, flash model preloaded with byte k = k[7:0]:
  - Bus shows CLE write 00h, then ALE writes 00h, 00h, 00h.
  - 512 bytes out as 00..FF twice.
  - done pulses once; busy is 0 the cycle after.
- Page 511:
  - ALE bytes are 00h, FFh, 01h.
  - Streamed data equals model page 511 contents (262144-byte image, offset 511*512).
- Backpressure: dout_ready toggled 1 cycle on / 3 off:
  - No byte lost or duplicated; f_ren stays 1 while the register is full.
  - Data stable during stalls; exactly 512 transfers.
- Fast RB model (RB never falls):
  - Read starts WB_MAX cycles after the third ALE write.
  - Output still matches the page.
- start pulsed during RD_LO of byte 100: ignored, stream continues to 512 bytes.
- rst=0 for one cycle at byte 200:
  - Next cycle all outputs are at reset values (f_wen=f_ren=1, busy=0, dout_valid=0).
  - A new start on page 3 completes correctly.
